// File: rtl/cmsdk_uart_stimulus.sv
// cmsdk_uart_stimulus: bench-side 8N1 UART transmitter fed from a small FIFO.
//   CLK, RESET (async, active-high)
//   DATA_IN/DATA_VALID/DATA_READY : byte push interface
//   TXD        : registered serial output, idle high
//   BUSY       : frame in progress or FIFO non-empty
//   FIFO_COUNT : queued bytes, excluding the one being shifted
// Optional feature: define CMSDK_UART_STIM_PARITY_EN for an even-parity bit.
module cmsdk_uart_stimulus #(
  parameter int BAUDDIV = 16,
  parameter int FIFO_AW = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         DATA_IN,
  input  logic               DATA_VALID,
  output logic               DATA_READY,
  output logic               TXD,
  output logic               BUSY,
  output logic [FIFO_AW:0]   FIFO_COUNT
);

  localparam int               DEPTH       = 1 << FIFO_AW;
  localparam logic [15:0]      BAUD_RELOAD = 16'(BAUDDIV - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CMSDK_UART_STIM_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic [7:0]           mem_q [DEPTH];

  logic push;
  logic pop;
  logic launch;
  logic fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign DATA_READY = (count_q != FULL_COUNT) && !RESET;
  assign push       = DATA_VALID && DATA_READY;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    launch    = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) launch = 1'b1;
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef CMSDK_UART_STIM_PARITY_EN
            state_d = S_PARITY;
            txd_d   = ^shift_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef CMSDK_UART_STIM_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = BAUD_RELOAD;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // IDLE and the last STOP cycle share the pop/start sequence so that
    // queued frames follow each other with no idle gap.
    if (launch) begin
      pop     = 1'b1;
      state_d = S_START;
      shift_d = mem_q[rd_ptr_q];
      baud_d  = BAUD_RELOAD;
      txd_d   = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= DATA_IN;
  end

  assign TXD        = txd_q;
  assign BUSY       = (state_q != S_IDLE) || !fifo_empty;
  assign FIFO_COUNT = count_q;

endmodule
